// File: rtl/lc3_writeback_if.sv
// Writeback-stage bundle: write strobe, source select, result buses, register addresses and the
// read-back ports (VSR1/VSR2/psr).
interface lc3_writeback_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8
);
  localparam int unsigned AddrWidth = $clog2(NUM_REGS);

  logic                  enable_writeback;
  logic [1:0]            W_Control;
  logic [DATA_WIDTH-1:0] aluout;
  logic [DATA_WIDTH-1:0] memout;
  logic [DATA_WIDTH-1:0] pcout;
  logic [AddrWidth-1:0]  dr;
  logic [AddrWidth-1:0]  sr1;
  logic [AddrWidth-1:0]  sr2;
  logic [DATA_WIDTH-1:0] VSR1;
  logic [DATA_WIDTH-1:0] VSR2;
  logic [2:0]            psr;

  modport master (
    output enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    input  VSR1, VSR2, psr
  );

  modport slave (
    input  enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    output VSR1, VSR2, psr
  );
endinterface

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: register file R0..R7 plus {N,Z,P} condition codes.
// Define WRITEBACK_BYPASS_EN to forward same-cycle write data onto the read ports.
module lc3_writeback #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8
) (
  input logic            clk,
  input logic            rst,
  lc3_writeback_if.slave wb
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr_en;
  logic [2:0]            psr_q;
  logic [2:0]            psr_d;

  // W_Control == 3 is a reserved select and acts as a no-op write.
  always_comb begin
    wdata = wb.aluout;
    case (wb.W_Control)
      2'd1:    wdata = wb.memout;
      2'd2:    wdata = wb.pcout;
      default: wdata = wb.aluout;
    endcase
    wr_en = wb.enable_writeback && (wb.W_Control != 2'd3);
  end

  always_comb begin
    psr_d = 3'b001;
    if (wdata[DATA_WIDTH-1]) begin
      psr_d = 3'b100;
    end else if (wdata == '0) begin
      psr_d = 3'b010;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      psr_q <= 3'b000;
    end else if (wr_en) begin
      regs_q[wb.dr] <= wdata;
      psr_q         <= psr_d;
    end
  end

  always_comb begin
    wb.VSR1 = regs_q[wb.sr1];
    wb.VSR2 = regs_q[wb.sr2];
`ifdef WRITEBACK_BYPASS_EN
    if (wr_en && (wb.dr == wb.sr1)) begin
      wb.VSR1 = wdata;
    end
    if (wr_en && (wb.dr == wb.sr2)) begin
      wb.VSR2 = wdata;
    end
`endif
  end

  assign wb.psr = psr_q;
endmodule

// File: tb/tb_lc3_writeback.sv
// Directed and randomized checks of lc3_writeback against an array-based register-file model.
module tb_lc3_writeback;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] ref_regs [8];
  logic [2:0]  ref_psr;

  lc3_writeback_if wb_if ();

  lc3_writeback dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] classify(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] selected();
    logic [15:0] src [3];
    src[0] = wb_if.aluout;
    src[1] = wb_if.memout;
    src[2] = wb_if.pcout;
    return src[wb_if.W_Control];
  endfunction

  function automatic logic writing();
    return wb_if.enable_writeback && (wb_if.W_Control != 2'd3);
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] sr);
`ifdef WRITEBACK_BYPASS_EN
    if (writing() && (wb_if.dr == sr)) return selected();
`endif
    return ref_regs[sr];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    ref_psr = 3'b000;
  endtask

  // Apply one rising edge and mirror its effect in the model.
  task automatic tick();
    logic        do_wr;
    logic [15:0] v;
    logic [2:0]  d;
    do_wr = writing();
    v     = selected();
    d     = wb_if.dr;
    @(posedge clk);
    if (do_wr) begin
      ref_regs[d] = v;
      ref_psr     = classify(v);
    end
    #1;
  endtask

  task automatic write(input logic [1:0] sel, input logic [2:0] d, input logic [15:0] v);
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control        = sel;
    wb_if.dr               = d;
    wb_if.aluout           = v;
    wb_if.memout           = v;
    wb_if.pcout            = v;
    tick();
    wb_if.enable_writeback = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_if.enable_writeback = 1'b0;
    wb_if.W_Control = 2'd0;
    wb_if.aluout = '0;
    wb_if.memout = '0;
    wb_if.pcout = '0;
    wb_if.dr = '0;
    wb_if.sr1 = '0;
    wb_if.sr2 = '0;
    clear_model();

    // Power-on reset.
    #2 rst = 1'b0;
    #1;
    check("por_psr", {13'd0, wb_if.psr}, 16'h0000);
    check("por_vsr1", wb_if.VSR1, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Write R3 then assert reset mid-simulation, off the clock edge.
    write(2'd0, 3'd3, 16'h1234);
    wb_if.sr1 = 3'd3;
    #1;
    check("r3_written", wb_if.VSR1, 16'h1234);
    check("r3_psr", {13'd0, wb_if.psr}, {13'd0, ref_psr});
    rst = 1'b0;
    clear_model();
    #1;
    check("rst_psr", {13'd0, wb_if.psr}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      wb_if.sr1 = 3'(i);
      #1;
      check($sformatf("rst_r%0d", i), wb_if.VSR1, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;

    // Source select on dr=2.
    wb_if.aluout = 16'h0005;
    wb_if.memout = 16'h8000;
    wb_if.pcout  = 16'h3000;
    wb_if.dr = 3'd2;
    wb_if.sr1 = 3'd2;
    wb_if.enable_writeback = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wb_if.W_Control = 2'(s);
      tick();
      check($sformatf("src%0d_vsr1", s), wb_if.VSR1, ref_regs[2]);
      check($sformatf("src%0d_psr", s), {13'd0, wb_if.psr}, {13'd0, ref_psr});
    end
    check("src_last", wb_if.VSR1, 16'h3000);

    // Zero result, then an idle cycle must hold psr and R7.
    write(2'd0, 3'd7, 16'h0000);
    wb_if.sr1 = 3'd7;
    #1;
    check("zero_r7", wb_if.VSR1, 16'h0000);
    check("zero_psr", {13'd0, wb_if.psr}, 16'h0002);
    wb_if.aluout = 16'hFFFF;
    tick();
    check("idle_r7", wb_if.VSR1, 16'h0000);
    check("idle_psr", {13'd0, wb_if.psr}, 16'h0002);

    // Reserved select is a no-op.
    write(2'd0, 3'd4, 16'h0001);
    write(2'd3, 3'd4, 16'hABCD);
    wb_if.sr1 = 3'd4;
    #1;
    check("rsv_r4", wb_if.VSR1, 16'h0001);
    check("rsv_psr", {13'd0, wb_if.psr}, 16'h0001);

    // Dual read and same-cycle read/write.
    write(2'd0, 3'd1, 16'h00AA);
    write(2'd0, 3'd6, 16'h0055);
    wb_if.sr1 = 3'd1;
    wb_if.sr2 = 3'd6;
    #1;
    check("dual_vsr1", wb_if.VSR1, 16'h00AA);
    check("dual_vsr2", wb_if.VSR2, 16'h0055);
    wb_if.sr1 = 3'd6;
    #1;
    check("same_vsr1", wb_if.VSR1, 16'h0055);
    check("same_vsr2", wb_if.VSR2, 16'h0055);
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd0;
    wb_if.dr = 3'd6;
    wb_if.aluout = 16'h7777;
    #1;
`ifdef WRITEBACK_BYPASS_EN
    check("rw_before", wb_if.VSR2, 16'h7777);
`else
    check("rw_before", wb_if.VSR2, 16'h0055);
`endif
    tick();
    wb_if.enable_writeback = 1'b0;
    check("rw_after", wb_if.VSR2, 16'h7777);

    // Back-to-back writes of every register.
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd0;
    for (int i = 0; i < 8; i++) begin
      wb_if.dr = 3'(i);
      wb_if.aluout = 16'h1000 + 16'(i);
      tick();
      check($sformatf("b2b_psr%0d", i), {13'd0, wb_if.psr}, 16'h0001);
    end
    wb_if.enable_writeback = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_if.sr1 = 3'(i);
      wb_if.sr2 = 3'(7 - i);
      #1;
      check($sformatf("b2b_r%0d", i), wb_if.VSR1, 16'h1000 + 16'(i));
      check($sformatf("b2b_rr%0d", 7 - i), wb_if.VSR2, ref_regs[7 - i]);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      wb_if.enable_writeback = 1'($urandom_range(0, 3) != 0);
      wb_if.W_Control = 2'($urandom_range(0, 3));
      wb_if.aluout = 16'($urandom);
      wb_if.memout = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      wb_if.pcout  = 16'($urandom);
      wb_if.dr  = 3'($urandom_range(0, 7));
      wb_if.sr1 = 3'($urandom_range(0, 7));
      wb_if.sr2 = 3'($urandom_range(0, 7));
      #1;
      check("rnd_vsr1", wb_if.VSR1, exp_read(wb_if.sr1));
      check("rnd_vsr2", wb_if.VSR2, exp_read(wb_if.sr2));
      tick();
      check("rnd_psr", {13'd0, wb_if.psr}, {13'd0, ref_psr});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc3_writeback.md
Name: lc3_writeback

Overview:
- Writeback stage of the LC3 pipeline: holds the 8-entry general-purpose register file and the condition-code register (PSR).
- Captures ALU, memory or PC results into a destination register, then drives the two source-operand read ports (VSR1/VSR2) and psr.
- Its outputs are exactly the signals the writeback_out agent monitors.
- Upstream it is fed by execute (aluout, pcout), memory access (memout) and the controller (enable_writeback, W_Control, register addresses).

Parameters:
- DATA_WIDTH, 16: register and result width.
- NUM_REGS, 8: register count; address width is $clog2(NUM_REGS) = 3.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- enable_writeback  input  1  write strobe from controller
- W_Control  input  2  write source select: 0 aluout, 1 memout, 2 pcout, 3 reserved
- aluout  input  16  execute-stage ALU result
- memout  input  16  memory-access load data
- pcout  input  16  PC-derived result (LEA/JSR link)
- dr  input  3  destination register address
- sr1  input  3  source register 1 address
- sr2  input  3  source register 2 address
- VSR1  output  16  contents of register sr1
- VSR2  output  16  contents of register sr2
- psr  output  3  condition codes {N,Z,P}

Behaviour:
- Reset: rst low asynchronously clears all R0..R7 to 16'h0000 and psr to 3'b000. With all registers zero, VSR1 and VSR2 read 0.
- Reset is held while rst=0. The first write is accepted on the first rising edge with rst=1.
- Write data: wdata = aluout / memout / pcout for W_Control 0 / 1 / 2.
- A write occurs on a rising edge when enable_writeback=1 and W_Control != 3: R[dr] <= wdata. Latency is 1 cycle: the new value is visible on VSR1/VSR2 after that edge.
- W_Control=3 with enable_writeback=1: no register write and no psr update. This is a legal no-op, not an error.
- PSR update happens on the same edge as a write:
  - N=1 if wdata[15]=1.
  - else Z=1 if wdata==0.
  - else P=1.
  - Exactly one bit is set after any write.
- psr holds its value when no write occurs.
- Reads: VSR1=R[sr1] and VSR2=R[sr2], combinational from the register array. No read enable.
- sr1==sr2 is legal; both ports return the same value.
- Same-cycle read and write of the same register (without the optional feature): reads return the pre-edge (old) value; the new value appears after the edge.
- Every register, including R0, is writable. There is no hard-wired zero.
- dr/sr1/sr2 span exactly 0..7. No out-of-range case exists at the default parameter.
- rst asserted mid-write: reset wins. The register and psr are cleared and the write is lost.
- Inputs are sampled only at the clock edge. aluout/memout/pcout changes between edges have no effect.

Optional Feature:
- Macro: WRITEBACK_BYPASS_EN.
- Defined: write-to-read forwarding.
  - When enable_writeback=1, W_Control != 3 and dr==sr1, VSR1 = wdata combinationally in the same cycle. Same rule for sr2 and VSR2.
  - psr is not bypassed; it still updates at the edge.
- Not defined: reads always return the stored array value (old value during a same-cycle write).

Test Plan:
1. Reset check: assert rst=0 mid-simulation after writing R3=16'h1234, then sweep sr1 over 0..7 -> VSR1=0 for all, psr=3'b000, immediately on rst fall without waiting for a clock edge.
2. Source select: write dr=2 with W_Control=0/1/2 and aluout=16'h0005, memout=16'h8000, pcout=16'h3000 on three successive edges; sr1=2 -> VSR1 reads 0005, 8000, 3000 in turn; psr reads 001, 100, 001.
3. Zero result: W_Control=0, aluout=0, dr=7, enable=1 -> R7=0, psr=3'b010. Next cycle enable=0 with aluout=16'hFFFF -> psr stays 010 and R7 stays 0.
4. Reserved select: W_Control=3, enable=1, dr=4, aluout=16'hABCD (R4 previously 16'h0001, psr=001) -> R4 stays 0001, psr stays 001.
5. Dual read / same-cycle read: R1=16'h00AA, R6=16'h0055; sr1=1, sr2=6 -> VSR1=00AA, VSR2=0055. sr1=sr2=6 -> both 0055. Write dr=6, aluout=16'h7777 with sr2=6:
   - without WRITEBACK_BYPASS_EN: VSR2=0055 before the edge, 7777 after.
   - with WRITEBACK_BYPASS_EN: VSR2=7777 in the same cycle.
6. Back-to-back writes: write R0..R7 with values 16'h1000+i on 8 consecutive edges, then read all -> each R[i]=1000+i; psr=001 after every write.
